// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for controllers that borrow the LEGv8 ALU:
// function-select codes, status bit positions and the multiply sequencer states.
package alu_ctrl_pkg;

    localparam int DATA_W = 64;

    // FS[4:2] picks the operation, FS[1:0] are the operand invert bits.
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    // Bit positions inside the {V,C,N,Z} status word.
    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_C = 2;
    localparam int STAT_V = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TEST = 3'd1,
        ST_ADD  = 3'd2,
        ST_SHL  = 3'd3,
        ST_SHR  = 3'd4,
        ST_DONE = 3'd5
    } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bundle between the multiply sequencer, the control unit and the shared ALU.
// The slave side is the sequencer; the master side is whoever drives start and
// returns the ALU result (control unit plus ALU at the parent level).
interface alu_mul_sequencer_if;
    import alu_ctrl_pkg::*;

    logic                start;
    logic [DATA_W-1:0]   multiplicand;
    logic [DATA_W-1:0]   multiplier;
    logic                ready;
    logic                done;
    logic [DATA_W-1:0]   product;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [4:0]          alu_fs;
    logic                alu_c0;
    logic [DATA_W-1:0]   alu_f;
    logic [3:0]          alu_status;

    modport master (
        output start, multiplicand, multiplier, alu_f, alu_status,
        input  ready, done, product, alu_a, alu_b, alu_fs, alu_c0
    );

    modport slave (
        input  start, multiplicand, multiplier, alu_f, alu_status,
        output ready, done, product, alu_a, alu_b, alu_fs, alu_c0
    );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 64x64 -> low-64 multiplier that reuses the datapath ALU.
// Each multiplier bit costs TEST (+ADD when the bit is set) + SHL + SHR; the
// loop stops as soon as the remaining multiplier reads back as zero.
module alu_mul_sequencer
    import alu_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_mul_sequencer_if.slave   bus
);

    seq_state_t          state;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   mcand;
    logic [DATA_W-1:0]   mplier;
    logic [DATA_W-1:0]   product_r;
    logic                ready_r;
    logic                done_r;
    logic                alu_zero;

    assign alu_zero    = bus.alu_status[STAT_Z];
    assign bus.ready   = ready_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign bus.alu_c0  = 1'b0;

    // Sequencer FSM: state, working registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            product_r <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc     <= '0;
                        mcand   <= bus.multiplicand;
                        mplier  <= bus.multiplier;
                        ready_r <= 1'b0;
                        state   <= ST_TEST;
                    end
                end
                ST_TEST: begin
                    // ALU passes mplier through OR 0, so Z means no bits remain.
                    if (alu_zero) begin
                        product_r <= acc;
                        done_r    <= 1'b1;
                        state     <= ST_DONE;
                    end else if (mplier[0]) begin
                        state <= ST_ADD;
                    end else begin
                        state <= ST_SHL;
                    end
                end
                ST_ADD: begin
                    acc   <= bus.alu_f;
                    state <= ST_SHL;
                end
                ST_SHL: begin
                    mcand <= bus.alu_f;
                    state <= ST_SHR;
                end
                ST_SHR: begin
                    mplier <= bus.alu_f;
                    state  <= ST_TEST;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU operand/function decode, purely from the current state and registers.
    always_comb begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_fs = FS_AND;
        case (state)
            ST_TEST: begin
                bus.alu_a  = mplier;
                bus.alu_fs = FS_OR;
            end
            ST_ADD: begin
                bus.alu_a  = acc;
                bus.alu_b  = mcand;
                bus.alu_fs = FS_ADD;
            end
            ST_SHL: begin
                bus.alu_a  = mcand;
                bus.alu_b  = DATA_W'(1);
                bus.alu_fs = FS_LSL;
            end
            ST_SHR: begin
                bus.alu_a  = mplier;
                bus.alu_b  = DATA_W'(1);
                bus.alu_fs = FS_LSR;
            end
            default: begin
                bus.alu_a  = '0;
                bus.alu_b  = '0;
                bus.alu_fs = FS_AND;
            end
        endcase
    end

endmodule
